// File: rtl/mac_led_encoder_if.sv
// ---------------------------------------------------------------------------
// mac_led_encoder_if
// Control/status bus between the MAC status logic and the LED serial encoder.
//   iEn        : auto-refresh enable (master -> encoder)
//   iKick      : one-cycle request for a single frame (master -> encoder)
//   iPortData  : per-port LED status, port p at [p*BITS_PER_PORT +: BITS_PER_PORT]
//   oBusy      : encoder is transmitting a frame (encoder -> master)
//   oFrameDone : one-cycle pulse on the last cycle of a frame (encoder -> master)
// ---------------------------------------------------------------------------
interface mac_led_encoder_if #(
    parameter int NUM_PORTS     = 4,
    parameter int BITS_PER_PORT = 16
);
    logic                               iEn;
    logic                               iKick;
    logic [NUM_PORTS*BITS_PER_PORT-1:0] iPortData;
    logic                               oBusy;
    logic                               oFrameDone;

    modport master (
        output iEn,
        output iKick,
        output iPortData,
        input  oBusy,
        input  oFrameDone
    );

    modport slave (
        input  iEn,
        input  iKick,
        input  iPortData,
        output oBusy,
        output oFrameDone
    );
endinterface

// File: rtl/mac_led_encoder.sv
// ---------------------------------------------------------------------------
// mac_led_encoder
// Serial LED-stream transmitter. Snapshots the parallel per-port LED status
// and sends it on LED_CLK0/LED_DATA0 as: a start pulse (DATA high then low),
// NUM_PORTS words of BITS_PER_PORT bits (port 0 first, MSB first, clock low
// then high per bit) and a stop half-period. Every non-idle state lasts
// HALF_DIV iClk cycles. Frames repeat every GAP_CYC idle cycles while iEn is
// high, or once per kick.
//
// Ports:
//   iClk      : system clock
//   iRstn     : asynchronous active-low reset
//   bus       : mac_led_encoder_if.slave (iEn, iKick, iPortData, oBusy,
//               oFrameDone)
//   LED_CLK0  : serial LED clock (registered)
//   LED_DATA0 : serial LED data (registered)
//
// Optional build macro MAC_LED_CHG_ONLY_EN: auto-refresh frames are only sent
// when iPortData differs from the last transmitted snapshot (which resets to
// zero); kicks always send.
// ---------------------------------------------------------------------------
module mac_led_encoder #(
    parameter int NUM_PORTS     = 4,
    parameter int BITS_PER_PORT = 16,
    parameter int HALF_DIV      = 3,
    parameter int GAP_CYC       = 1000
) (
    input  logic                iClk,
    input  logic                iRstn,
    mac_led_encoder_if.slave    bus,
    output logic                LED_CLK0,
    output logic                LED_DATA0
);

    localparam int TOTAL_W = NUM_PORTS * BITS_PER_PORT;
    localparam int PH_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int GAP_W   = $clog2(GAP_CYC + 1);
    localparam int BIT_W   = (BITS_PER_PORT > 1) ? $clog2(BITS_PER_PORT) : 1;
    localparam int PORT_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int IDX_W   = (TOTAL_W > 1) ? $clog2(TOTAL_W) : 1;

    localparam logic [PH_W-1:0]   LAST_PH  = PH_W'(HALF_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYC);
    localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(BITS_PER_PORT - 1);
    localparam logic [PORT_W-1:0] PORT_MAX = PORT_W'(NUM_PORTS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_HI,
        START_LO,
        BIT_LO,
        BIT_HI,
        STOP
    } state_e;

    state_e              state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [PORT_W-1:0]   port_q, port_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [TOTAL_W-1:0]  snap_q, snap_d;
    logic                kick_q, kick_d;
    logic                led_clk_q, led_clk_d;
    logic                led_data_q, led_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                last_ph;
    logic                start_req;
    logic [IDX_W-1:0]    idx_d;

`ifdef MAC_LED_CHG_ONLY_EN
    logic [TOTAL_W-1:0]  sent_q, sent_d;
    logic                changed;
`endif

    always_comb begin
        last_ph = (phase_q == LAST_PH);

`ifdef MAC_LED_CHG_ONLY_EN
        changed   = (bus.iPortData != sent_q);
        start_req = (bus.iEn && (gap_q == '0) && changed) || kick_q;
        sent_d    = sent_q;
`else
        start_req = (bus.iEn && (gap_q == '0)) || kick_q;
`endif

        state_d = state_q;
        phase_d = '0;
        gap_d   = gap_q;
        port_d  = port_q;
        bit_d   = bit_q;
        snap_d  = snap_q;
        // Kicks arriving at any time collapse into the single latch bit.
        kick_d  = kick_q | bus.iKick;

        if (state_q != IDLE) begin
            phase_d = last_ph ? '0 : phase_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end
                if (start_req) begin
                    state_d = START_HI;
                    snap_d  = bus.iPortData;
                    kick_d  = 1'b0;
                    port_d  = '0;
                    bit_d   = BIT_MAX;
`ifdef MAC_LED_CHG_ONLY_EN
                    sent_d  = bus.iPortData;
`endif
                end
            end
            START_HI: if (last_ph) state_d = START_LO;
            START_LO: if (last_ph) state_d = BIT_LO;
            BIT_LO:   if (last_ph) state_d = BIT_HI;
            BIT_HI: begin
                if (last_ph) begin
                    if (bit_q != '0) begin
                        bit_d   = bit_q - 1'b1;
                        state_d = BIT_LO;
                    end else if (port_q != PORT_MAX) begin
                        // Port boundary looks exactly like a bit boundary.
                        port_d  = port_q + 1'b1;
                        bit_d   = BIT_MAX;
                        state_d = BIT_LO;
                    end else begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (last_ph) begin
                    state_d = IDLE;
                    gap_d   = GAP_LOAD;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are computed from the next state so the pins change on
        // state entry, in step with the state register.
        idx_d      = IDX_W'(int'(port_d) * BITS_PER_PORT + int'(bit_d));
        led_clk_d  = (state_d == BIT_HI);
        led_data_d = (state_d == START_HI) ||
                     (((state_d == BIT_LO) || (state_d == BIT_HI)) && snap_d[idx_d]);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == STOP) && (phase_d == LAST_PH);
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            gap_q      <= '0;
            port_q     <= '0;
            bit_q      <= '0;
            snap_q     <= '0;
            kick_q     <= 1'b0;
            led_clk_q  <= 1'b0;
            led_data_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MAC_LED_CHG_ONLY_EN
            sent_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            gap_q      <= gap_d;
            port_q     <= port_d;
            bit_q      <= bit_d;
            snap_q     <= snap_d;
            kick_q     <= kick_d;
            led_clk_q  <= led_clk_d;
            led_data_q <= led_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef MAC_LED_CHG_ONLY_EN
            sent_q     <= sent_d;
`endif
        end
    end

    assign LED_CLK0       = led_clk_q;
    assign LED_DATA0      = led_data_q;
    assign bus.oBusy      = busy_q;
    assign bus.oFrameDone = done_q;

endmodule

// File: tb/tb_mac_led_encoder.sv
// ---------------------------------------------------------------------------
// tb_mac_led_encoder
// Self-checking bench for mac_led_encoder. A frame reference is derived from
// the frame layout (half-period index -> expected pin levels) and the LED
// stream is also decoded back into port words.
// ---------------------------------------------------------------------------
module tb_mac_led_encoder;

    localparam int NP    = 4;
    localparam int BPP   = 16;
    localparam int HD    = 3;
    localparam int GAP   = 200;
    localparam int TOT   = NP * BPP;
    localparam int FRAME = (2 + 2 * TOT + 1) * HD;

    logic iClk  = 1'b0;
    logic iRstn = 1'b1;
    logic LED_CLK0;
    logic LED_DATA0;

    int total = 0;
    int bad   = 0;

    mac_led_encoder_if #(.NUM_PORTS(NP), .BITS_PER_PORT(BPP)) bus ();

    mac_led_encoder #(
        .NUM_PORTS    (NP),
        .BITS_PER_PORT(BPP),
        .HALF_DIV     (HD),
        .GAP_CYC      (GAP)
    ) dut (
        .iClk     (iClk),
        .iRstn    (iRstn),
        .bus      (bus.slave),
        .LED_CLK0 (LED_CLK0),
        .LED_DATA0(LED_DATA0)
    );

    always #5 iClk = ~iClk;

    // Expected {clk,data} at cycle k of a frame carrying d.
    function automatic logic [1:0] model_pins(input int k, input logic [TOT-1:0] d);
        int h, n, p, b;
        logic [5:0] idx;
        h = k / HD;
        if (h == 0) return 2'b01;
        if (h == 1 || h >= (FRAME / HD) - 1) return 2'b00;
        n   = (h - 2) / 2;
        p   = n / BPP;
        b   = BPP - 1 - (n % BPP);
        idx = 6'(p * BPP + b);
        return {((h - 2) % 2) == 1, d[idx]};
    endfunction

    function automatic logic [TOT-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic wait_start(input int budget, input string name);
        int w = 0;
        while (bus.oBusy !== 1'b1 && w < budget) begin
            @(negedge iClk);
            w++;
        end
        total++;
        if (bus.oBusy !== 1'b1) begin
            bad++;
            $display("FAIL %s start: busy=%b after %0d cycles, need 1 within %0d",
                     name, bus.oBusy, w, budget);
        end
    endtask

    // Called on the first negedge with busy high; returns on the negedge
    // after the last frame cycle.
    task automatic check_frame(input logic [TOT-1:0] exp, input int kick_a, input int kick_b,
                               input int chg_at, input logic [TOT-1:0] chg_val,
                               input string name);
        int errs = 0, first = -1, nbits = 0;
        logic [3:0] act, want, fa, fe;
        logic [1:0] m;
        logic prev = 1'b0;
        logic [TOT-1:0] dec = '0;
        logic [5:0] di;
        fa = '0;
        fe = '0;
        for (int k = 0; k < FRAME; k++) begin
            m    = model_pins(k, exp);
            want = {m, 1'b1, k == FRAME - 1};
            act  = {LED_CLK0, LED_DATA0, bus.oBusy, bus.oFrameDone};
            if (act !== want) begin
                if (first < 0) begin
                    first = k;
                    fa = act;
                    fe = want;
                end
                errs++;
            end
            if (LED_CLK0 === 1'b1 && prev === 1'b0) begin
                if (nbits < TOT) begin
                    di = 6'((nbits / BPP) * BPP + BPP - 1 - (nbits % BPP));
                    dec[di] = LED_DATA0;
                end
                nbits++;
            end
            prev = LED_CLK0;
            bus.iKick = (k == kick_a) || (k == kick_b);
            if (k == chg_at) bus.iPortData = chg_val;
            @(negedge iClk);
        end
        bus.iKick = 1'b0;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s wave: %0d bad cycles, first at %0d clk/dat/busy/done got %b need %b",
                     name, errs, first, fa, fe);
        end
        total++;
        if (dec !== exp) begin
            bad++;
            $display("FAIL %s decode: got %h need %h", name, dec, exp);
        end
        total++;
        if (nbits != TOT) begin
            bad++;
            $display("FAIL %s bitcount: got %0d need %0d", name, nbits, TOT);
        end
        total++;
        if ({LED_CLK0, LED_DATA0, bus.oBusy} !== 3'b000) begin
            bad++;
            $display("FAIL %s post: clk/dat/busy got %b need 000", name,
                     {LED_CLK0, LED_DATA0, bus.oBusy});
        end
    endtask

    task automatic wait_quiet(input int n, input string name);
        int errs = 0;
        for (int i = 0; i < n; i++) begin
            if ({LED_CLK0, LED_DATA0, bus.oBusy, bus.oFrameDone} !== 4'b0000) errs++;
            @(negedge iClk);
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s quiet: %0d active cycles, need 0", name, errs);
        end
    endtask

    task automatic test_reset();
        bus.iEn       = 1'b1;
        bus.iKick     = 1'b0;
        bus.iPortData = '0;
        #2 iRstn = 1'b0;
        repeat (3) @(negedge iClk);
        total++;
        if (LED_CLK0 !== 1'b0) begin
            bad++;
            $display("FAIL reset clk: got %b need 0", LED_CLK0);
        end
        total++;
        if (LED_DATA0 !== 1'b0) begin
            bad++;
            $display("FAIL reset data: got %b need 0", LED_DATA0);
        end
        total++;
        if ({bus.oBusy, bus.oFrameDone} !== 2'b00) begin
            bad++;
            $display("FAIL reset status: busy/done got %b need 00", {bus.oBusy, bus.oFrameDone});
        end
    endtask

    task automatic test_zero_frame();
        iRstn = 1'b1;
`ifdef MAC_LED_CHG_ONLY_EN
        bus.iKick = 1'b1;
        @(negedge iClk);
        bus.iKick = 1'b0;
        wait_start(3, "zero");
`else
        wait_start(2, "zero");
`endif
        check_frame('0, -1, -1, -1, '0, "zero");
    endtask

    task automatic test_patterns();
        logic [TOT-1:0] d, prevd;
        d = {4{16'h3FFF}};
        bus.iPortData = d;
        wait_start(GAP + 10, "p3fff");
        check_frame(d, -1, -1, -1, '0, "p3fff");
        d = {16'hA955, 16'h8155, 16'hAA55, 16'h0155};
        bus.iPortData = d;
        wait_start(GAP + 10, "order");
        check_frame(d, -1, -1, -1, '0, "order");
        for (int i = 0; i < 3; i++) begin
            prevd = d;
            d = rand64();
            if (d == prevd) d = ~d;
            bus.iPortData = d;
            wait_start(GAP + 10, "random");
            check_frame(d, -1, -1, -1, '0, "random");
        end
    endtask

    task automatic test_kick();
        logic [TOT-1:0] d;
        bus.iEn = 1'b0;
        wait_quiet(GAP + 50, "en_off");
        d = rand64();
        bus.iPortData = d;
        bus.iKick = 1'b1;
        @(negedge iClk);
        bus.iKick = 1'b0;
        wait_start(3, "kick1");
        check_frame(d, 50, 200, -1, '0, "kick1");
        wait_start(3, "kick2");
        check_frame(d, -1, -1, -1, '0, "kick2");
        wait_quiet(GAP + 50, "after_kick");
    endtask

    task automatic test_snapshot();
        logic [TOT-1:0] a, b;
        a = rand64();
        b = rand64();
        if (a == b) b = ~a;
        bus.iPortData = a;
        bus.iEn = 1'b1;
        wait_start(GAP + 10, "snap_old");
        check_frame(a, -1, -1, 6 * HD + 20 * 2 * HD, b, "snap_old");
        wait_start(GAP + 10, "snap_new");
        check_frame(b, -1, -1, -1, '0, "snap_new");
    endtask

    task automatic test_reset_mid();
        logic [TOT-1:0] d, d2;
        d = rand64();
        if (d == bus.iPortData) d = ~d;
        bus.iPortData = d;
        wait_start(GAP + 10, "rst_mid");
        repeat (2 * HD + 40 * 2 * HD) @(negedge iClk);
        iRstn = 1'b0;
        #1;
        total++;
        if ({LED_CLK0, LED_DATA0, bus.oBusy, bus.oFrameDone} !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset: clk/dat/busy/done got %b need 0000",
                     {LED_CLK0, LED_DATA0, bus.oBusy, bus.oFrameDone});
        end
        @(negedge iClk);
        iRstn = 1'b1;
        wait_start(3, "after_rst");
        check_frame(d, -1, -1, -1, '0, "after_rst");
`ifdef MAC_LED_CHG_ONLY_EN
        wait_quiet(GAP + 50, "unchanged");
        d2 = rand64();
        if (d2 == d) d2 = ~d;
        bus.iPortData = d2;
        wait_start(5, "changed");
        check_frame(d2, -1, -1, -1, '0, "changed");
`else
        d2 = d;
        wait_start(GAP + 10, "refresh");
        check_frame(d2, -1, -1, -1, '0, "refresh");
`endif
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_patterns();
        test_kick();
        test_snapshot();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
